// File: rtl/sprite_animator.sv
// Walk-cycle sequencer: turns vsync rises into frame ticks and steps a 4-frame walk animation.
// sel updates on the 3rd Clk edge after a frame_clk rise; no backpressure, all outputs registered except frame_tick.
module sprite_animator #(
    parameter int unsigned HOLD_FRAMES = 8,
    parameter logic [7:0]  KEY_RIGHT   = 8'd79,
    parameter logic [7:0]  KEY_LEFT    = 8'd80
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] Keycode,
    output logic [3:0] sel,
    output logic [1:0] frame_idx,
    output logic       walking,
    output logic       facing_left,
    output logic       frame_tick
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WALK_R = 2'd1;
    localparam logic [1:0] ST_WALK_L = 2'd2;

    // A zero hold count is treated as one tick per frame.
    localparam logic [3:0] HOLD_LAST = (HOLD_FRAMES == 0) ? 4'd0 : 4'(HOLD_FRAMES - 1);

    logic       sync1_q, sync2_q, sync3_q;
    logic [1:0] state_q, state_d;
    logic       face_q, face_d;
    logic [1:0] frame_q, frame_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] sel_q, sel_d;
    logic [1:0] target;

    assign frame_tick = sync2_q & ~sync3_q;

    always_comb begin
        state_d = state_q;
        face_d  = face_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        target  = ST_IDLE;
        if (Keycode == KEY_RIGHT) begin
            target = ST_WALK_R;
        end else if (Keycode == KEY_LEFT) begin
            target = ST_WALK_L;
        end

        if (frame_tick) begin
            state_d = target;
            if (target == ST_IDLE) begin
                frame_d = 2'd0;
                hold_d  = 4'd0;
            end else begin
                face_d = (target == ST_WALK_L);
                if (target != state_q) begin
                    frame_d = 2'd1;
                    hold_d  = 4'd0;
                end else if (hold_q >= HOLD_LAST) begin
                    frame_d = frame_q + 2'd1;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
        end
        // Built from next-state values so sel never lags frame_idx/facing_left.
        sel_d = {(face_d ? 2'b01 : 2'b10), frame_d};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            state_q <= ST_IDLE;
            face_q  <= 1'b0;
            frame_q <= 2'd0;
            hold_q  <= 4'd0;
            sel_q   <= 4'b1000;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            face_q  <= face_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    assign sel         = sel_q;
    assign frame_idx   = frame_q;
    assign walking     = (state_q != ST_IDLE);
    assign facing_left = face_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: three instances (HOLD_FRAMES 2, 1, 0) share stimulus and are checked every cycle.
module tb_sprite_animator;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] Keycode;

    logic [3:0] sel_w  [3];
    logic [1:0] fidx_w [3];
    logic       walk_w [3];
    logic       face_w [3];
    logic       tick_w [3];

    always #10 Clk = ~Clk;

    sprite_animator #(.HOLD_FRAMES(2)) u_hold2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .sel(sel_w[0]), .frame_idx(fidx_w[0]), .walking(walk_w[0]),
        .facing_left(face_w[0]), .frame_tick(tick_w[0]));

    sprite_animator #(.HOLD_FRAMES(1)) u_hold1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .sel(sel_w[1]), .frame_idx(fidx_w[1]), .walking(walk_w[1]),
        .facing_left(face_w[1]), .frame_tick(tick_w[1]));

    sprite_animator #(.HOLD_FRAMES(0)) u_hold0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .sel(sel_w[2]), .frame_idx(fidx_w[2]), .walking(walk_w[2]),
        .facing_left(face_w[2]), .frame_tick(tick_w[2]));

    int n_checks  = 0;
    int n_errors  = 0;
    int dut_ticks = 0;
    int vs_cnt    = 0;

    // Reference model: direction 0=idle 1=right 2=left, plain integer frame/hold counters.
    int hf [3] = '{2, 1, 0};
    int m_dir [3];
    int m_face [3];
    int m_frame [3];
    int m_hold [3];
    // frame_clk as seen 1, 2 and 3 edges ago (cleared by reset)
    bit h1, h2, h3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_sel(input int i);
        return (m_face[i] != 0 ? 4 : 8) + m_frame[i];
    endfunction

    task automatic model_edge(input bit fc, input logic [7:0] key, input bit rst);
        bit t;
        int nd;
        int lim;
        t = h2 & ~h3;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_dir[i] = 0; m_face[i] = 0; m_frame[i] = 0; m_hold[i] = 0;
            end else if (t) begin
                nd  = (key == 8'd79) ? 1 : (key == 8'd80) ? 2 : 0;
                lim = (hf[i] == 0) ? 1 : hf[i];
                if (nd == 0) begin
                    m_dir[i] = 0; m_frame[i] = 0; m_hold[i] = 0;
                end else if (nd != m_dir[i]) begin
                    m_dir[i] = nd; m_face[i] = (nd == 2) ? 1 : 0;
                    m_frame[i] = 1; m_hold[i] = 0;
                end else if (m_hold[i] == lim - 1) begin
                    m_hold[i] = 0; m_frame[i] = (m_frame[i] + 1) % 4;
                end else begin
                    m_hold[i] = m_hold[i] + 1;
                end
            end
        end
        if (!rst) begin
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            h3 = h2; h2 = h1; h1 = fc;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sel[%0d]", i), 32'(sel_w[i]), 32'(exp_sel(i)));
            check($sformatf("frame_idx[%0d]", i), 32'(fidx_w[i]), 32'(m_frame[i]));
            check($sformatf("walking[%0d]", i), 32'(walk_w[i]), 32'(m_dir[i] != 0));
            check($sformatf("facing_left[%0d]", i), 32'(face_w[i]), 32'(m_face[i]));
            check($sformatf("frame_tick[%0d]", i), 32'(tick_w[i]), 32'(h2 & ~h3));
        end
        if (tick_w[0] === 1'b1) dut_ticks++;
    endtask

    task automatic cycle(input bit fc, input logic [7:0] key, input bit rst);
        frame_clk = fc;
        Keycode   = key;
        Reset     = rst;
        @(posedge Clk);
        model_edge(fc, key, rst);
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic vsync(input logic [7:0] key, input int hi, input int lo);
        vs_cnt++;
        repeat (hi) cycle(1'b1, key, 1'b1);
        repeat (lo) cycle(1'b0, key, 1'b1);
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 3))
            0:       return 8'd79;
            1:       return 8'd80;
            2:       return ($urandom_range(0, 1) != 0) ? 8'd79 : 8'd80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int seq2 [9] = '{9, 9, 10, 10, 11, 11, 8, 8, 9};
    int seq3 [3] = '{5, 6, 7};

    initial begin
        logic [7:0] key;
        int hi, lo;

        // reset held with frame_clk toggling and a walk key present
        cycle(1'b1, 8'd79, 1'b0);
        check("rst_sel", 32'(sel_w[0]), 32'd8);
        cycle(1'b0, 8'd79, 1'b0);
        check("rst_sel2", 32'(sel_w[0]), 32'd8);
        check("rst_walk", 32'(walk_w[0]), 32'd0);
        cycle(1'b0, 8'd79, 1'b1);
        check("sel_after_release", 32'(sel_w[0]), 32'd8);

        for (int k = 0; k < 9; k++) begin
            vsync(8'd79, 4, 4);
            check("walk_right_seq", 32'(sel_w[0]), 32'(seq2[k]));
            check("walk_right_walking", 32'(walk_w[0]), 32'd1);
        end

        for (int k = 0; k < 3; k++) begin
            vsync(8'd80, 2, 4);
            check("walk_left_seq", 32'(sel_w[1]), 32'(seq3[k]));
        end
        vsync(8'd0, 2, 4);
        check("stand_left_sel", 32'(sel_w[1]), 32'd4);
        check("stand_left_walk", 32'(walk_w[1]), 32'd0);
        check("stand_left_face", 32'(face_w[1]), 32'd1);

        repeat (3) vsync(8'd79, 3, 4);
        check("right_at_10", 32'(sel_w[0]), 32'd10);
        vsync(8'd80, 3, 4);
        check("reverse_sel", 32'(sel_w[0]), 32'd5);
        check("reverse_face", 32'(face_w[0]), 32'd1);

        // keycode activity strictly between ticks
        repeat (2) cycle(1'b0, 8'd0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1);
        check("idle_after_reset", 32'(sel_w[0]), 32'd8);
        dut_ticks = 0;
        vs_cnt    = 0;
        vsync(8'd0, 3, 5);
        repeat (100) cycle(1'b0, 8'd79, 1'b1);
        repeat (3) cycle(1'b0, 8'd0, 1'b1);
        vsync(8'd0, 3, 5);
        check("between_ticks_sel", 32'(sel_w[0]), 32'd8);
        check("between_ticks_walk", 32'(walk_w[0]), 32'd0);
        check("tick_count", 32'(dut_ticks), 32'(vs_cnt));

        dut_ticks = 0;
        repeat (1000) cycle(1'b1, 8'd0, 1'b1);
        repeat (4) cycle(1'b0, 8'd0, 1'b1);
        check("held_high_ticks", 32'(dut_ticks), 32'd1);

        // reset coinciding with a tick while walking
        vsync(8'd79, 3, 5);
        check("walking_before_reset", 32'(walk_w[0]), 32'd1);
        cycle(1'b1, 8'd79, 1'b1);
        cycle(1'b1, 8'd79, 1'b1);
        check("tick_before_reset", 32'(tick_w[0]), 32'd1);
        cycle(1'b1, 8'd79, 1'b0);
        check("reset_on_tick_sel", 32'(sel_w[0]), 32'd8);
        check("reset_on_tick_walk", 32'(walk_w[0]), 32'd0);
        check("reset_on_tick_tick", 32'(tick_w[0]), 32'd0);
        cycle(1'b1, 8'd79, 1'b1);
        check("release_tick_1", 32'(tick_w[0]), 32'd0);
        cycle(1'b1, 8'd79, 1'b1);
        check("release_tick_2", 32'(tick_w[0]), 32'd1);
        repeat (3) cycle(1'b0, 8'd79, 1'b1);
        check("restart_frame1", 32'(sel_w[0]), 32'd9);

        // randomized walk: random vsync widths, keys, mid-pulse key changes and resets
        repeat (250) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(1, 2)) cycle(1'($urandom_range(0, 1)), pick_key(), 1'b0);
            end else begin
                key = pick_key();
                hi  = $urandom_range(1, 6);
                lo  = $urandom_range(1, 6);
                repeat (hi) begin
                    if ($urandom_range(0, 9) == 0) key = pick_key();
                    cycle(1'b1, key, 1'b1);
                end
                repeat (lo) begin
                    if ($urandom_range(0, 9) == 0) key = pick_key();
                    cycle(1'b0, key, 1'b1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Walk-cycle sequencer that drives the sprite-select code for the player sprite.
- Runs on the system clock and samples `frame_clk` (vertical sync) as a data input, turning each vsync rising edge into a one-cycle frame tick.
- On each tick it reads the keyboard keycode, tracks facing and walking state, and steps through a 4-frame walk animation.
- `sel` feeds the sprite ROM address mux; position update stays in the motion block.

Parameters:
- HOLD_FRAMES, 8, number of frame ticks each walk frame is displayed (legal range 1..15; 0 behaves as 1).
- KEY_RIGHT, 8'd79, keycode for walking right.
- KEY_LEFT, 8'd80, keycode for walking left.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-low reset, sampled on the `Clk` rising edge.
- frame_clk  input  1  vertical sync level; asynchronous to `Clk`, so it is synchronised internally.
- Keycode  input  8  current keycode from the keyboard interface.
- sel  output  4  sprite select: {facing code, frame index}.
- frame_idx  output  2  current animation frame, 0..3.
- walking  output  1  1 while in a WALK state.
- facing_left  output  1  0 = facing right, 1 = facing left.
- frame_tick  output  1  one-`Clk` pulse per `frame_clk` rising edge.

Behaviour:
- Synchroniser: `frame_clk` passes through two flops (s1, s2), then a history flop (s3).
  - frame_tick = s2 & ~s3 (combinational).
  - sel first shows the new value after the 3rd `Clk` rising edge following the `frame_clk` rise.
  - A high level that is held produces exactly one tick.
- States: IDLE, WALK_R, WALK_L. Keycode is sampled only in cycles where frame_tick=1; keycode changes between ticks are ignored.
- Transitions on tick:
  - Keycode==KEY_RIGHT → WALK_R, facing_left=0.
  - Keycode==KEY_LEFT → WALK_L, facing_left=1.
  - Any other keycode → IDLE; facing_left keeps its value.
- Entering a WALK state (from IDLE, or reversing direction): frame_idx=1, hold_cnt=0.
- Staying in the same WALK state on a tick:
  - If hold_cnt==HOLD_FRAMES-1 (HOLD_FRAMES=0 treated as 1): hold_cnt=0, frame_idx=frame_idx+1 mod 4 (3→0 wraps).
  - Otherwise: hold_cnt+1.
- IDLE: frame_idx=0, hold_cnt=0.
- hold_cnt is 4 bits and never exceeds HOLD_FRAMES-1.
- sel is registered and always consistent with state:
  - facing_left=0 → sel={2'b10, frame_idx}, i.e. 8..11; 8 = standing right.
  - facing_left=1 → sel={2'b01, frame_idx}, i.e. 4..7; 4 = standing left.
- walking = (state != IDLE).
- Reset (Reset==0 at a `Clk` edge) dominates everything, including a simultaneous tick:
  - state=IDLE, facing_left=0, frame_idx=0, hold_cnt=0, sel=4'b1000, walking=0.
  - s1/s2/s3 cleared, so frame_tick=0 the cycle after reset.
  - If `frame_clk` is already high when reset releases, one tick fires 2 cycles after release (s3 starts at 0).
- Reset mid-walk: next cycle outputs are the reset values; the animation restarts from frame 1 on the first tick with a walk keycode.
- No other outputs change between ticks.

Test Plan:
- Reset low 2 cycles with `frame_clk` toggling, Keycode=79 → sel=8, frame_idx=0, walking=0, facing_left=0 throughout reset; sel=8 the cycle after release.
- HOLD_FRAMES=2, Keycode=79 held, 9 vsync ticks → sel sequence after each tick: 9,9,10,10,11,11,8,8,9 (wrap 11→8 as frame 0 while walking=1).
- Keycode=80 held 3 ticks (HOLD_FRAMES=1), then Keycode=0 → sel 5,6,7, then 4 with walking=0, facing_left=1.
- Walking right at sel=10, Keycode switches to 80 mid-hold → next tick sel=5, hold_cnt=0, facing_left=1.
- Keycode pulses 79 for 100 cycles strictly between ticks → no change; sel stays 8 and frame_tick count equals vsync count.
- `frame_clk` held high 1000 cycles → exactly one frame_tick. Reset asserted in the same cycle as a tick while walking → sel=8, walking=0 next cycle.
